// File: rtl/example_rx_pkg.sv
// example_rx_pkg: shared constants, pointer-width helper and pointer type for
// the example_rx_buffer receive FIFO.
//   DROP_CNT_WIDTH : width of the optional saturating drop counter
//   ptr_width()    : pointer width for a given depth (index bits plus wrap bit)
//   ptr_t          : pointer type for the default depth
package example_rx_pkg;

    localparam int unsigned DROP_CNT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH  = 4;

    // One extra MSB distinguishes full from empty when the index bits match.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned PTR_WIDTH = ptr_width(DEFAULT_DEPTH);

    typedef logic [PTR_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/example_rx_fifo.sv
// example_rx_fifo: storage array, read/write pointers and full/empty/level
// logic for the receive buffer. Reads are combinational from the head slot.
// Ports:
//   clk, rst      clock; synchronous active-high reset of the pointers
//   push, wdata   write wdata at the tail (caller guarantees !full || pop)
//   pop           advance the head (caller guarantees !empty)
//   rdata         word at the head slot (undefined content when empty)
//   full, empty   occupancy flags
//   level         occupancy 0..DEPTH
module example_rx_fifo
    import example_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PTR_W     = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_W-1:0]      level
);

    localparam int unsigned ADDR_W = PTR_W - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/example_rx_buffer.sv
// example_rx_buffer: receive-side buffer for a producer without backpressure.
// Strobed words are queued in a small FIFO and offered downstream through
// valid/ready. Words arriving while full (and not draining) are dropped and
// flagged in a sticky overflow bit.
// Ports:
//   clk_i, rst_i       clock; synchronous active-high reset
//   data_in_i          producer word, qualified by valid_in_i (single cycle)
//   data_o, valid_o    head word (forced to 0 when empty) and non-empty flag
//   ready_i            consumer accept; pop happens on valid_o && ready_i
//   level_o            occupancy 0..DEPTH
//   overflow_o         sticky drop flag, cleared by clr_ovf_i
//   drop_count_o       saturating drop counter, only when
//                      EXAMPLE_RX_BUFFER_STATS_EN is defined
module example_rx_buffer
    import example_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_WIDTH-1:0]      data_in_i,
    input  logic                       valid_in_i,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    input  logic                       clr_ovf_i
`ifdef EXAMPLE_RX_BUFFER_STATS_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0]  drop_count_o
`endif
);

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  overflow_flag;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop  = !empty && ready_i;
    assign push = valid_in_i && (!full || pop);
    assign drop = valid_in_i && full && !pop;

    example_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (data_in_i),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_flag <= 1'b0;
        end else if (drop) begin
            overflow_flag <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow_flag <= 1'b0;
        end
    end

    assign overflow_o = overflow_flag;
    assign valid_o    = !empty;
    assign data_o     = empty ? '0 : rdata;

`ifdef EXAMPLE_RX_BUFFER_STATS_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end

    assign drop_count_o = drop_cnt;
`endif

endmodule

// File: tb/tb_example_rx_buffer.sv
// tb_example_rx_buffer: self-checking bench for example_rx_buffer. A queue
// model tracks stored words, the sticky overflow flag and the drop count.
module tb_example_rx_buffer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vin = 1'b0;
    logic          rdy = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] data;
    logic          valid;
    logic [LW-1:0] level;
    logic          ovf;
`ifdef EXAMPLE_RX_BUFFER_STATS_EN
    logic [15:0]   dcnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    example_rx_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_in_i  (din),
        .valid_in_i (vin),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (rdy),
        .level_o    (level),
        .overflow_o (ovf),
        .clr_ovf_i  (clr)
`ifdef EXAMPLE_RX_BUFFER_STATS_EN
        ,
        .drop_count_o (dcnt)
`endif
    );

    // Apply one cycle of inputs, advance the model, wait for the edge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r,
                         input bit c, input bit rs);
        bit pop_m;
        bit drop_m;
        vin = v; din = d; rdy = r; clr = c; rst = rs;
        if (rs) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            pop_m  = (mq.size() != 0) && r;
            drop_m = v && (mq.size() == DEPTH) && !pop_m;
            if (pop_m) void'(mq.pop_front());
            if (v && !drop_m) mq.push_back(d);
            if (drop_m) begin
                m_ovf = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end else if (c) begin
                m_ovf = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        vin = 1'b0; rdy = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        cycle(0, '0, 0, 0, 1);
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid); end
        n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
        n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf); end
`ifdef EXAMPLE_RX_BUFFER_STATS_EN
        n_cmp++; if (dcnt !== 16'h0) begin n_fail++; $display("FAIL reset_dcnt got %0d want 0", dcnt); end
`endif
    endtask

    task automatic test_single();
        cycle(1, 8'hA5, 0, 0, 0);
        n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", valid); end
        n_cmp++; if (data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", data); end
        n_cmp++; if (level !== LW'(1)) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
        cycle(0, '0, 1, 0, 0);
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %0b want 0", valid); end
        n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL single_pop_data got %h want 00", data); end
        // ready with empty FIFO must do nothing
        cycle(0, '0, 1, 0, 0);
        n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL empty_ready_level got %0d want 0", level); end
    endtask

    task automatic test_overflow();
        cycle(0, '0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cycle(1, DW'(i), 0, 0, 0);
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_before_drop got %0b want 0", ovf); end
        cycle(1, 8'h05, 0, 0, 0);
        n_cmp++; if (level !== LW'(4)) begin n_fail++; $display("FAIL ovf_level got %0d want 4", level); end
        n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", ovf); end
`ifdef EXAMPLE_RX_BUFFER_STATS_EN
        n_cmp++; if (dcnt !== 16'd1) begin n_fail++; $display("FAIL ovf_dcnt got %0d want 1", dcnt); end
`endif
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (data !== DW'(i)) begin n_fail++; $display("FAIL ovf_drain got %h want %h", data, DW'(i)); end
            cycle(0, '0, 1, 0, 0);
        end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_valid got %0b want 0", valid); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, DW'(8'h10 + i), 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            exp = (i < 4) ? DW'(8'h10 + i) : DW'(8'h20 + i - 4);
            n_cmp++;
            if (data !== exp) begin n_fail++; $display("FAIL b2b_order[%0d] got %h want %h", i, data, exp); end
            cycle(1, DW'(8'h20 + i), 1, 0, 0);
            n_cmp++;
            if (level !== LW'(4)) begin n_fail++; $display("FAIL b2b_level[%0d] got %0d want 4", i, level); end
        end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got %0b want 0", ovf); end
`ifdef EXAMPLE_RX_BUFFER_STATS_EN
        n_cmp++; if (dcnt !== 16'd0) begin n_fail++; $display("FAIL b2b_dcnt got %0d want 0", dcnt); end
`endif
    endtask

    task automatic test_reset_flush();
        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, DW'(8'hA0 + i), 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);
        n_cmp++; if (level !== LW'(2)) begin n_fail++; $display("FAIL flush_pre_level got %0d want 2", level); end
        cycle(1, 8'h77, 1, 0, 1);
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", valid); end
        n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL flush_level got %0d want 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL flush_ovf got %0b want 0", ovf); end
        n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL flush_data got %h want 00", data); end
        cycle(1, 8'hCC, 0, 0, 0);
        n_cmp++; if (data !== 8'hCC) begin n_fail++; $display("FAIL flush_new_data got %h want cc", data); end
        n_cmp++; if (level !== LW'(1)) begin n_fail++; $display("FAIL flush_new_level got %0d want 1", level); end
        cycle(0, '0, 1, 0, 0);
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale got valid %0b want 0", valid); end
    endtask

    task automatic test_clr_ovf();
        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, DW'(i), 0, 0, 0);
        cycle(1, 8'h55, 0, 1, 0);
        n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL clr_with_drop got %0b want 1", ovf); end
        cycle(0, '0, 0, 1, 0);
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_alone got %0b want 0", ovf); end
        n_cmp++; if (level !== LW'(4)) begin n_fail++; $display("FAIL clr_level got %0d want 4", level); end
`ifdef EXAMPLE_RX_BUFFER_STATS_EN
        n_cmp++; if (dcnt !== 16'd2) begin n_fail++; $display("FAIL clr_dcnt got %0d want 2", dcnt); end
`endif
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d;
        logic [LW-1:0] exp_l;
        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(99) < 60), DW'($urandom), ($urandom_range(99) < 45),
                  ($urandom_range(15) == 0), ($urandom_range(63) == 0));
            exp_d = (mq.size() != 0) ? mq[0] : '0;
            exp_l = LW'(mq.size());
            n_cmp++;
            if (valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid[%0d] got %0b want %0b", i, valid, mq.size() != 0); end
            n_cmp++;
            if (data !== exp_d) begin n_fail++; $display("FAIL rand_data[%0d] got %h want %h", i, data, exp_d); end
            n_cmp++;
            if (level !== exp_l) begin n_fail++; $display("FAIL rand_level[%0d] got %0d want %0d", i, level, exp_l); end
            n_cmp++;
            if (ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d] got %0b want %0b", i, ovf, m_ovf); end
`ifdef EXAMPLE_RX_BUFFER_STATS_EN
            n_cmp++;
            if (dcnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_dcnt[%0d] got %0d want %0d", i, dcnt, m_cnt); end
`endif
        end
    endtask

`ifdef EXAMPLE_RX_BUFFER_STATS_EN
    task automatic test_stats_saturate();
        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, DW'(i), 0, 0, 0);
        for (int i = 0; i < 65540; i++) cycle(1, DW'(i), 0, 0, 0);
        n_cmp++; if (dcnt !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat got %h want ffff", dcnt); end
        cycle(0, '0, 0, 1, 0);
        n_cmp++; if (dcnt !== 16'hFFFF) begin n_fail++; $display("FAIL stats_clr got %h want ffff", dcnt); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL stats_ovf_clr got %0b want 0", ovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_reset_flush();
        test_clr_ovf();
        test_random();
`ifdef EXAMPLE_RX_BUFFER_STATS_EN
        test_stats_saturate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
